// File: rtl/i2c_codec_target.sv
// rtl/i2c_codec_target.sv - I2C target modelling the codec control port with a byte register file.
// Optional macro I2C_CODEC_TARGET_AUTOINC_EN: advance the register pointer after every data byte.
module i2c_codec_target #(
    parameter logic [6:0] DEV_ADDR   = 7'h34,
    parameter int         REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic                  wr_stb,
    output logic [REG_ADDR_W-1:0] wr_addr,
    output logic [7:0]            wr_data,
    input  logic [REG_ADDR_W-1:0] tap_addr,
    output logic [7:0]            tap_data,
    output logic                  busy
);

    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    typedef enum logic [3:0] {
        IDLE, DEV, DEV_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
    } state_t;

    state_t                state, state_n;
    logic [2:0]            bit_cnt, bit_cnt_n;
    logic [7:0]            shreg, shreg_n;
    logic [REG_ADDR_W-1:0] pointer, pointer_n, ptr_adv;
    logic                  phase, phase_n;
    logic                  sda_oe_n, busy_n, wr_stb_n;
    logic [REG_ADDR_W-1:0] wr_addr_n;
    logic [7:0]            wr_data_n;
    logic [7:0]            regs [NUM_REGS];
    logic [7:0]            rx_byte, rd_byte;

    logic scl_s1, scl_s, scl_d;
    logic sda_s1, sda_s, sda_d;
    logic scl_rise, scl_fall, start_ev, stop_ev;

    // Sync flops reset to the idle-bus level so leaving reset never fakes an event.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_s1 <= 1'b1; scl_s <= 1'b1; scl_d <= 1'b1;
            sda_s1 <= 1'b1; sda_s <= 1'b1; sda_d <= 1'b1;
        end else begin
            scl_s1 <= scl_in; scl_s <= scl_s1; scl_d <= scl_s;
            sda_s1 <= sda_in; sda_s <= sda_s1; sda_d <= sda_s;
        end
    end

    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    assign start_ev = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_ev  = scl_s & scl_d & ~sda_d & sda_s;

`ifdef I2C_CODEC_TARGET_AUTOINC_EN
    assign ptr_adv = pointer + REG_ADDR_W'(1);
`else
    assign ptr_adv = pointer;
`endif

    assign rx_byte  = {shreg[6:0], sda_s};
    assign rd_byte  = regs[pointer];
    assign tap_data = regs[tap_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            pointer <= '0;
            phase   <= 1'b0;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            wr_stb  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            pointer <= pointer_n;
            phase   <= phase_n;
            sda_oe  <= sda_oe_n;
            busy    <= busy_n;
            wr_stb  <= wr_stb_n;
            wr_addr <= wr_addr_n;
            wr_data <= wr_data_n;
            // Commit one clk after the strobe so a same-index tap sees the old value during it.
            if (wr_stb) regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        pointer_n = pointer;
        phase_n   = phase;
        sda_oe_n  = sda_oe;
        busy_n    = busy;
        wr_stb_n  = 1'b0;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;

        if (stop_ev) begin
            state_n  = IDLE;
            sda_oe_n = 1'b0;
            busy_n   = 1'b0;
            phase_n  = 1'b0;
        end else if (start_ev) begin
            state_n   = DEV;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b1;
            phase_n   = 1'b0;
        end else begin
            case (state)
                DEV, REG, WDATA: begin
                    if (scl_rise) begin
                        shreg_n   = rx_byte;
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            phase_n = 1'b0;
                            if (state == DEV) begin
                                state_n = (rx_byte[7:1] == DEV_ADDR) ? DEV_ACK : WAIT_STOP;
                            end else if (state == REG) begin
                                pointer_n = rx_byte[REG_ADDR_W-1:0];
                                state_n   = REG_ACK;
                            end else begin
                                wr_stb_n  = 1'b1;
                                wr_addr_n = pointer;
                                wr_data_n = rx_byte;
                                pointer_n = ptr_adv;
                                state_n   = WDATA_ACK;
                            end
                        end
                    end
                end
                DEV_ACK, REG_ACK, WDATA_ACK: begin
                    // phase=0: waiting for the fall that starts the ACK; phase=1: ACK on the bus.
                    if (scl_fall) begin
                        if (!phase) begin
                            sda_oe_n = 1'b1;
                            phase_n  = 1'b1;
                        end else begin
                            sda_oe_n  = 1'b0;
                            phase_n   = 1'b0;
                            bit_cnt_n = '0;
                            if (state == DEV_ACK && shreg[0]) begin
                                state_n  = RDATA;
                                sda_oe_n = ~rd_byte[7];
                                shreg_n  = {rd_byte[6:0], 1'b0};
                            end else if (state == DEV_ACK) begin
                                state_n = REG;
                            end else begin
                                state_n = WDATA;
                            end
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state_n = RDATA_ACK;
                            phase_n = 1'b0;
                        end
                    end else if (scl_fall) begin
                        sda_oe_n = ~shreg[7];
                        shreg_n  = {shreg[6:0], 1'b0};
                    end
                end
                RDATA_ACK: begin
                    // phase=1 once the master has ACKed; the next fall starts the following byte.
                    if (scl_fall) begin
                        if (phase) begin
                            state_n   = RDATA;
                            phase_n   = 1'b0;
                            bit_cnt_n = '0;
                            sda_oe_n  = ~rd_byte[7];
                            shreg_n   = {rd_byte[6:0], 1'b0};
                        end else begin
                            sda_oe_n = 1'b0;
                        end
                    end else if (scl_rise) begin
                        if (!sda_s) begin
                            phase_n   = 1'b1;
                            pointer_n = ptr_adv;
                        end else begin
                            state_n = WAIT_STOP;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_codec_target.sv
// tb/tb_i2c_codec_target.sv - directed bench for i2c_codec_target with a write-strobe scoreboard.
module tb_i2c_codec_target;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       scl_in, sda_in, sda_oe, wr_stb, busy;
    logic [4:0] wr_addr, tap_addr;
    logic [7:0] wr_data, tap_data;

    int n_cmp = 0;
    int n_err = 0;
    logic oe_seen = 1'b0;

    typedef struct {
        logic [4:0] a;
        logic [7:0] d;
    } wr_t;
    wr_t        wr_q[$];
    logic [7:0] rd_q[$];

    always #10 clk = ~clk;

    assign scl_in = scl_m;
    assign sda_in = sda_m & ~sda_oe;

    i2c_codec_target #(.DEV_ADDR(7'h34), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
        .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
        .tap_addr(tap_addr), .tap_data(tap_data), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && wr_stb !== 1'b0) begin
            if (wr_q.size() == 0) begin
                check("unexpected_wr_stb", {31'b0, wr_stb}, 32'd0);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                check("wr_addr", {27'b0, wr_addr}, {27'b0, e.a});
                check("wr_data", {24'b0, wr_data}, {24'b0, e.d});
            end
        end
        if (sda_oe === 1'b1) oe_seen = 1'b1;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic m_start();
        sda_m = 1'b1; wait_clks(5);
        scl_m = 1'b1; wait_clks(10);
        sda_m = 1'b0; wait_clks(10);
        scl_m = 1'b0; wait_clks(5);
    endtask

    task automatic m_stop();
        sda_m = 1'b0; wait_clks(5);
        scl_m = 1'b1; wait_clks(10);
        sda_m = 1'b1; wait_clks(10);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    wait_clks(5);
        scl_m = 1'b1; wait_clks(10);
        scl_m = 1'b0; wait_clks(5);
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; wait_clks(5);
        scl_m = 1'b1; wait_clks(5);
        b = sda_in;   wait_clks(5);
        scl_m = 1'b0; wait_clks(5);
    endtask

    task automatic send_byte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
        recv_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] v, input logic ack);
        for (int i = 7; i >= 0; i--) recv_bit(v[i]);
        send_bit(ack);
    endtask

    task automatic tap_check(input logic [4:0] a, input logic [7:0] exp, input string tag);
        tap_addr = a;
        #1;
        check(tag, {24'b0, tap_data}, {24'b0, exp});
    endtask

    task automatic write_txn(input logic [4:0] r, input logic [7:0] d);
        logic ack;
        m_start();
        send_byte(8'h68, ack); check("w_dev_ack", {31'b0, ack}, 32'd0);
        send_byte({3'b0, r}, ack); check("w_reg_ack", {31'b0, ack}, 32'd0);
        wr_q.push_back('{a: r, d: d});
        send_byte(d, ack); check("w_data_ack", {31'b0, ack}, 32'd0);
        m_stop();
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd, exp_rd;
        tap_addr = '0;

        // Reset and idle bus
        wait_clks(5);
        rst = 1'b0;
        wait_clks(100);
        check("idle_sda_oe", {31'b0, sda_oe}, 32'd0);
        check("idle_busy", {31'b0, busy}, 32'd0);
        for (int i = 0; i < 32; i++) tap_check(i[4:0], 8'h00, "reset_tap");

        // Single write
        m_start();
        check("busy_after_start", {31'b0, busy}, 32'd1);
        send_byte(8'h68, ack); check("dev_ack", {31'b0, ack}, 32'd0);
        send_byte(8'h12, ack); check("reg_ack", {31'b0, ack}, 32'd0);
        wr_q.push_back('{a: 5'h12, d: 8'h80});
        send_byte(8'h80, ack); check("data_ack", {31'b0, ack}, 32'd0);
        m_stop();
        check("busy_after_stop", {31'b0, busy}, 32'd0);
        check("wr_q_drained_1", wr_q.size(), 32'd0);
        tap_check(5'h12, 8'h80, "tap_12");

        // Two data bytes from the top index
        m_start();
        send_byte(8'h68, ack); check("dev_ack2", {31'b0, ack}, 32'd0);
        send_byte(8'h1F, ack); check("reg_ack2", {31'b0, ack}, 32'd0);
        wr_q.push_back('{a: 5'h1F, d: 8'hA5});
        send_byte(8'hA5, ack); check("data_ack2a", {31'b0, ack}, 32'd0);
`ifdef I2C_CODEC_TARGET_AUTOINC_EN
        wr_q.push_back('{a: 5'h00, d: 8'h5A});
`else
        wr_q.push_back('{a: 5'h1F, d: 8'h5A});
`endif
        send_byte(8'h5A, ack); check("data_ack2b", {31'b0, ack}, 32'd0);
        m_stop();
        check("wr_q_drained_2", wr_q.size(), 32'd0);
`ifdef I2C_CODEC_TARGET_AUTOINC_EN
        tap_check(5'h1F, 8'hA5, "tap_1f");
        tap_check(5'h00, 8'h5A, "tap_00_wrap");
`else
        tap_check(5'h1F, 8'h5A, "tap_1f");
        tap_check(5'h00, 8'h00, "tap_00_untouched");
`endif

        // Seed the neighbour, then combined read from 0x12
        write_txn(5'h13, 8'h3C);
        m_start();
        send_byte(8'h68, ack); check("rd_dev_w_ack", {31'b0, ack}, 32'd0);
        send_byte(8'h12, ack); check("rd_reg_ack", {31'b0, ack}, 32'd0);
        m_start();
        send_byte(8'h69, ack); check("rd_dev_r_ack", {31'b0, ack}, 32'd0);
        rd_q.push_back(8'h80);
`ifdef I2C_CODEC_TARGET_AUTOINC_EN
        rd_q.push_back(8'h3C);
`else
        rd_q.push_back(8'h80);
`endif
        recv_byte(rd, 1'b0);
        exp_rd = rd_q.pop_front();
        check("rd_byte0", {24'b0, rd}, {24'b0, exp_rd});
        recv_byte(rd, 1'b1);
        exp_rd = rd_q.pop_front();
        check("rd_byte1", {24'b0, rd}, {24'b0, exp_rd});
        wait_clks(3);
        check("sda_released_after_nack", {31'b0, sda_oe}, 32'd0);
        m_stop();
        check("busy_after_read", {31'b0, busy}, 32'd0);

        // Foreign address
        oe_seen = 1'b0;
        m_start();
        send_byte(8'h6A, ack); check("foreign_dev_nack", {31'b0, ack}, 32'd1);
        send_byte(8'hFF, ack); check("foreign_data_nack", {31'b0, ack}, 32'd1);
        check("foreign_oe_never", {31'b0, oe_seen}, 32'd0);
        m_stop();
        check("wr_q_drained_3", wr_q.size(), 32'd0);

        // Reset mid data byte
        m_start();
        send_byte(8'h68, ack); check("pre_rst_dev_ack", {31'b0, ack}, 32'd0);
        send_byte(8'h05, ack); check("pre_rst_reg_ack", {31'b0, ack}, 32'd0);
        for (int i = 7; i >= 4; i--) send_bit(1'b1);
        check("busy_before_rst", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        wait_clks(1);
        check("rst_sda_oe", {31'b0, sda_oe}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        wait_clks(2);
        rst = 1'b0;
        tap_check(5'h12, 8'h00, "rst_tap_12");
        tap_check(5'h13, 8'h00, "rst_tap_13");
        tap_check(5'h1F, 8'h00, "rst_tap_1f");
        scl_m = 1'b1; wait_clks(10);
        sda_m = 1'b1; wait_clks(20);
        write_txn(5'h07, 8'h11);
        check("wr_q_drained_4", wr_q.size(), 32'd0);
        tap_check(5'h07, 8'h11, "post_rst_tap_07");
        check("final_busy", {31'b0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
